// File: rtl/sw_job_tracker.sv
// sw_job_tracker: per-channel outstanding-job tracker for the Smith-Waterman
// datapath. Each channel counts accepted starts against completions. It drives
// an enable while work is pending and holds starts off once the channel is at
// its depth limit. Protocol misuse and stalled jobs raise sticky error flags,
// and those flags are ORed into a single interrupt.
//
// Handshake: start[c]/start_ready[c] behave as a valid/ready pair. A start is
// accepted on a rising edge where start[c] and start_ready[c] are both high.
// start_ready depends only on registered state and never on start in the same
// cycle. A start raised while start_ready is low is dropped and flagged rather
// than held. done[c] is a fire-and-forget completion pulse with no ready.
module sw_job_tracker #(
  parameter int NUM_CH  = 4,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = $clog2(MAX_OUT + 1),
  parameter int TO_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [TO_W-1:0]         timeout_cycles,
  input  logic [NUM_CH-1:0]       start,
  output logic [NUM_CH-1:0]       start_ready,
  input  logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       en,
  output logic [NUM_CH*CNT_W-1:0] pending_cnt,
  output logic                    all_idle,
  output logic [NUM_CH-1:0]       err_overflow,
  output logic [NUM_CH-1:0]       err_underflow,
  output logic [NUM_CH-1:0]       err_timeout,
  output logic                    irq
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TO_W-1:0]  WD_MAX   = '1;
  localparam logic [TO_W-1:0]  WD_ONE   = TO_W'(1);

  // Registered per-channel state.
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [TO_W-1:0]   wd_q  [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] unf_q;
  logic [NUM_CH-1:0] tmo_q;

  // Next-state values.
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [TO_W-1:0]   wd_d  [NUM_CH];
  logic [NUM_CH-1:0] ovf_d;
  logic [NUM_CH-1:0] unf_d;
  logic [NUM_CH-1:0] tmo_d;

  logic [NUM_CH-1:0] acc;

  // Status outputs derived only from registers (no start -> ready path).
  always_comb begin
    start_ready = '0;
    en          = '0;
    pending_cnt = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      start_ready[ch]                    = (cnt_q[ch] < MAX_CNT);
      en[ch]                             = (cnt_q[ch] != '0);
      pending_cnt[ch*CNT_W +: CNT_W]     = cnt_q[ch];
    end
  end

  assign acc           = start & start_ready;
  assign all_idle      = ~|en;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign err_timeout   = tmo_q;
  assign irq           = |{ovf_q, unf_q, tmo_q};

  // Per-channel counter, watchdog and error-flag next state.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    tmo_d = tmo_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      wd_d[ch]  = wd_q[ch];
    end

    if (clear) begin
      // clear swallows same-cycle start/done and raises no flags.
      ovf_d = '0;
      unf_d = '0;
      tmo_d = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_d[ch] = '0;
        wd_d[ch]  = '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        // Pending count: a start and done together cancel, which also covers
        // a zero-latency job at cnt == 0.
        if (acc[ch] && !done[ch]) begin
          cnt_d[ch] = cnt_q[ch] + CNT_ONE;
        end else if (!acc[ch] && done[ch] && (cnt_q[ch] != '0)) begin
          cnt_d[ch] = cnt_q[ch] - CNT_ONE;
        end

        if (start[ch] && !start_ready[ch]) begin
          ovf_d[ch] = 1'b1;
        end
        if (done[ch] && !acc[ch] && (cnt_q[ch] == '0)) begin
          unf_d[ch] = 1'b1;
        end

        // Watchdog counts cycles without progress while work is pending.
        if ((cnt_d[ch] == '0) || acc[ch] || done[ch]) begin
          wd_d[ch] = '0;
        end else if (wd_q[ch] != WD_MAX) begin
          wd_d[ch] = wd_q[ch] + WD_ONE;
        end

        if ((timeout_cycles != '0) && (cnt_d[ch] != '0) &&
            (wd_d[ch] == timeout_cycles)) begin
          tmo_d[ch] = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
      unf_q <= '0;
      tmo_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= '0;
        wd_q[ch]  <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      tmo_q <= tmo_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
        wd_q[ch]  <= wd_d[ch];
      end
    end
  end

endmodule

// File: tb/tb_sw_job_tracker.sv
// Bench for sw_job_tracker: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_sw_job_tracker;

  localparam int NUM_CH  = 4;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);
  localparam int TO_W    = 16;
  localparam int WD_MAX  = (1 << TO_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    clear = 1'b0;
  logic [TO_W-1:0]         timeout_cycles = '0;
  logic [NUM_CH-1:0]       start = '0;
  logic [NUM_CH-1:0]       done = '0;
  logic [NUM_CH-1:0]       start_ready;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH*CNT_W-1:0] pending_cnt;
  logic                    all_idle;
  logic [NUM_CH-1:0]       err_overflow;
  logic [NUM_CH-1:0]       err_underflow;
  logic [NUM_CH-1:0]       err_timeout;
  logic                    irq;

  sw_job_tracker #(
    .NUM_CH(NUM_CH), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .timeout_cycles(timeout_cycles),
    .start(start), .start_ready(start_ready), .done(done), .en(en),
    .pending_cnt(pending_cnt), .all_idle(all_idle),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_timeout(err_timeout), .irq(irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per channel: number of jobs in flight, cycles since last progress, and
  // sticky error bits, updated from the rules at each rising edge.
  int m_cnt [NUM_CH];
  int m_wd  [NUM_CH];
  int m_ovf [NUM_CH];
  int m_unf [NUM_CH];
  int m_tmo [NUM_CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] <= 0; m_wd[c] <= 0; m_ovf[c] <= 0; m_unf[c] <= 0; m_tmo[c] <= 0;
      end
    end else if (clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] <= 0; m_wd[c] <= 0; m_ovf[c] <= 0; m_unf[c] <= 0; m_tmo[c] <= 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        int  jobs;
        int  idle;
        bit  took;
        took = start[c] && (m_cnt[c] < MAX_OUT);
        jobs = m_cnt[c] + (took ? 1 : 0) - ((done[c] && (m_cnt[c] > 0 || took)) ? 1 : 0);
        if (start[c] && !took) m_ovf[c] <= 1;
        if (done[c] && !took && m_cnt[c] == 0) m_unf[c] <= 1;
        if (jobs == 0 || took || done[c]) idle = 0;
        else idle = (m_wd[c] >= WD_MAX) ? WD_MAX : m_wd[c] + 1;
        if (int'(timeout_cycles) != 0 && jobs != 0 && idle == int'(timeout_cycles))
          m_tmo[c] <= 1;
        m_cnt[c] <= jobs;
        m_wd[c]  <= idle;
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  logic [NUM_CH*CNT_W-1:0] exp_q[$];

  always @(negedge clk) begin
    logic [NUM_CH*CNT_W-1:0] e_cnt;
    logic [NUM_CH-1:0] e_en, e_rdy, e_ovf, e_unf, e_tmo;
    for (int c = 0; c < NUM_CH; c++) begin
      e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
      e_en[c]  = (m_cnt[c] != 0);
      e_rdy[c] = (m_cnt[c] < MAX_OUT);
      e_ovf[c] = (m_ovf[c] != 0);
      e_unf[c] = (m_unf[c] != 0);
      e_tmo[c] = (m_tmo[c] != 0);
    end
    exp_q.push_back(e_cnt);
    check("pending_cnt", 64'(pending_cnt), 64'(exp_q.pop_front()));
    check("en", 64'(en), 64'(e_en));
    check("start_ready", 64'(start_ready), 64'(e_rdy));
    check("all_idle", 64'(all_idle), 64'(e_en == '0));
    check("err_overflow", 64'(err_overflow), 64'(e_ovf));
    check("err_underflow", 64'(err_underflow), 64'(e_unf));
    check("err_timeout", 64'(err_timeout), 64'(e_tmo));
    check("irq", 64'(irq), 64'(|{e_ovf, e_unf, e_tmo}));
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives one cycle and returns at the next falling edge.
  task automatic step(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] d, input logic c);
    start = s;
    done  = d;
    clear = c;
    @(negedge clk);
    start = '0;
    done  = '0;
    clear = 1'b0;
  endtask

  function automatic int cnt_of(input int ch);
    return int'(pending_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("reset_en", 64'(en), 64'h0);
    check("reset_ready", 64'(start_ready), 64'hF);
    check("reset_idle", 64'(all_idle), 64'h1);
    check("reset_irq", 64'(irq), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single job on ch0.
    step(4'b0001, 4'b0000, 1'b0);
    check("t1_en_up", 64'(en[0]), 64'h1);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0001, 1'b0);
    check("t1_en_down", 64'(en[0]), 64'h0);
    check("t1_idle", 64'(all_idle), 64'h1);
    check("t1_noerr", 64'({err_overflow, err_underflow, err_timeout}), 64'h0);

    // Depth limit on ch1.
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 4'b0000, 1'b0);
      check("t2_cnt1", 64'(cnt_of(1)), 64'((i < 4) ? i + 1 : 4));
      if (i == 3) check("t2_ready_low", 64'(start_ready[1]), 64'h0);
    end
    check("t2_ovf", 64'(err_overflow), 64'h2);
    check("t2_irq", 64'(irq), 64'h1);
    step(4'b0000, 4'b0000, 1'b1);

    // Underflow on ch2, then zero-latency job.
    step(4'b0000, 4'b0100, 1'b0);
    check("t3_unf", 64'(err_underflow), 64'h4);
    check("t3_cnt2", 64'(cnt_of(2)), 64'h0);
    step(4'b0100, 4'b0100, 1'b0);
    check("t3_zl_cnt2", 64'(cnt_of(2)), 64'h0);
    check("t3_zl_unf", 64'(err_underflow), 64'h4);
    check("t3_zl_ovf", 64'(err_overflow), 64'h0);
    step(4'b0000, 4'b0000, 1'b1);

    // Watchdog on ch3.
    timeout_cycles = 16'd5;
    step(4'b1000, 4'b0000, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(4'b0000, 4'b0000, 1'b0);
      check("t4_tmo", 64'(err_timeout[3]), 64'((k == 5) ? 1 : 0));
    end
    step(4'b0000, 4'b1000, 1'b1);
    step(4'b1000, 4'b0000, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(4'b0000, (k == 4) ? 4'b1000 : 4'b0000, 1'b0);
    end
    check("t4_no_tmo", 64'(err_timeout), 64'h0);
    check("t4_cnt3", 64'(cnt_of(3)), 64'h0);
    timeout_cycles = '0;

    // Clear with same-cycle start.
    for (int i = 0; i < 5; i++) step(4'b0010, 4'b0000, 1'b0);
    step(4'b0000, 4'b0100, 1'b0);
    check("t5_pre_irq", 64'(irq), 64'h1);
    step(4'b0001, 4'b0000, 1'b1);
    check("t5_errs", 64'({err_overflow, err_underflow, err_timeout}), 64'h0);
    check("t5_irq", 64'(irq), 64'h0);
    check("t5_cnt0", 64'(cnt_of(0)), 64'h0);
    check("t5_en0", 64'(en[0]), 64'h0);
    step(4'b0000, 4'b0000, 1'b0);
    check("t5_en0_hold", 64'(en[0]), 64'h0);

    // Asynchronous reset with jobs pending.
    step(4'b0111, 4'b0000, 1'b0);
    check("t6_pre_en", 64'(en), 64'h7);
    #2 rst = 1'b1;
    #1;
    check("t6_en", 64'(en), 64'h0);
    check("t6_cnt", 64'(pending_cnt), 64'h0);
    check("t6_ready", 64'(start_ready), 64'hF);
    check("t6_idle", 64'(all_idle), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0001, 4'b0000, 1'b0);
    check("t6_resume", 64'(en), 64'h1);
    step(4'b0000, 4'b0001, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [NUM_CH-1:0] s, d;
      if ($urandom_range(0, 99) == 0) timeout_cycles = TO_W'($urandom_range(0, 8));
      s = NUM_CH'($urandom_range(0, 15)) & NUM_CH'($urandom_range(0, 15));
      d = NUM_CH'($urandom_range(0, 15)) & NUM_CH'($urandom_range(0, 15));
      step(s, d, ($urandom_range(0, 79) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
